// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Hazard detection and forwarding-select generation for the dual-issue pipeline.
//   The ID-stage bundle's source operands are compared against the destinations
//   of the instructions in EX and MEM. The resulting forw/stall/is_hold codes are
//   registered, so they are valid while that bundle sits in EX. The unit also
//   drives the PC and IF/ID freeze for load-use bubbles and intra-bundle splits,
//   and it keeps a saturating count of frozen cycles.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   id_valid                      ID bundle present
//   id_rs1_1/id_rs2_1/id_use*_1   lane1 sources and their use flags
//   id_rd_1/id_we_1/id_load_1     lane1 destination, write enable, is-load
//   id_rs1_2/id_rs2_2/id_use*_2   lane2 sources and their use flags
//   ex_rd_*/ex_we_*/ex_load_*     EX-stage lane1/2 destination info
//   mem_rd_*/mem_we_*             MEM-stage lane1/2 destination info
//   forw_1A/1B/2A/2B              registered operand select per lane/operand
//                                 0 regfile, 1 EX/MEM A, 2 EX/MEM B, 3 MEM/WB A,
//                                 4 MEM/WB B, 8 ALU1 same cycle (lane2 only)
//   stall_1/2                     registered bubble code (0 issue, 1 bubble)
//   is_hold_1/2                   registered split-hold code (1 slot withheld)
//   pc_hold/ifid_hold             combinational freeze of PC and IF/ID
//   stall_cnt                     saturating count of cycles with pc_hold=1
module hazard_forward_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_1,
    input  logic                      id_use1_1,
    input  logic                      id_use2_1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_1,
    input  logic                      id_we_1,
    input  logic                      id_load_1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_2,
    input  logic                      id_use1_2,
    input  logic                      id_use2_2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_1,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_2,
    input  logic                      ex_we_1,
    input  logic                      ex_we_2,
    input  logic                      ex_load_1,
    input  logic                      ex_load_2,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_1,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_2,
    input  logic                      mem_we_1,
    input  logic                      mem_we_2,
    output logic [3:0]                forw_1A,
    output logic [3:0]                forw_1B,
    output logic [3:0]                forw_2A,
    output logic [3:0]                forw_2B,
    output logic [3:0]                stall_1,
    output logic [3:0]                stall_2,
    output logic [3:0]                is_hold_1,
    output logic [3:0]                is_hold_2,
    output logic                      pc_hold,
    output logic                      ifid_hold,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [3:0] forw_1a_n, forw_1b_n, forw_2a_n, forw_2b_n;
    logic [3:0] stall_1_n, stall_2_n, is_hold_1_n, is_hold_2_n;
    logic       hold_c;
    logic       lu_1, lu_2, split_dep;

    // Forward select for one source. Lane B beats lane A inside a stage because
    // it is the younger instruction; EX beats MEM for the same reason.
    function automatic logic [3:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] src,
                                           input logic                      use_src,
                                           input logic                      allow_alu1);
        fwd_sel = 4'd0;
        if (use_src && src != '0) begin
            if (allow_alu1 && id_we_1 && !id_load_1 && src == id_rd_1)
                fwd_sel = 4'd8;
            else if (ex_we_2 && src == ex_rd_2)
                fwd_sel = 4'd2;
            else if (ex_we_1 && src == ex_rd_1)
                fwd_sel = 4'd1;
            else if (mem_we_2 && src == mem_rd_2)
                fwd_sel = 4'd4;
            else if (mem_we_1 && src == mem_rd_1)
                fwd_sel = 4'd3;
        end
    endfunction

    // A used non-x0 source that needs a value still being loaded in EX.
    function automatic logic load_hit(input logic [REG_ADDR_WIDTH-1:0] src,
                                      input logic                      use_src);
        load_hit = use_src && src != '0 &&
                   ((ex_load_1 && ex_we_1 && src == ex_rd_1) ||
                    (ex_load_2 && ex_we_2 && src == ex_rd_2));
    endfunction

    // A lane2 source that depends on a load issued in lane1 of the same bundle.
    function automatic logic intra_hit(input logic [REG_ADDR_WIDTH-1:0] src,
                                       input logic                      use_src);
        intra_hit = use_src && src != '0 && id_we_1 && id_load_1 && src == id_rd_1;
    endfunction

    always_comb begin
        lu_1      = load_hit(id_rs1_1, id_use1_1) | load_hit(id_rs2_1, id_use2_1);
        lu_2      = load_hit(id_rs1_2, id_use1_2) | load_hit(id_rs2_2, id_use2_2);
        split_dep = intra_hit(id_rs1_2, id_use1_2) | intra_hit(id_rs2_2, id_use2_2);
    end

    always_comb begin
        state_next  = state;
        hold_c      = 1'b0;
        forw_1a_n   = 4'd0;
        forw_1b_n   = 4'd0;
        forw_2a_n   = 4'd0;
        forw_2b_n   = 4'd0;
        stall_1_n   = 4'd0;
        stall_2_n   = 4'd0;
        is_hold_1_n = 4'd0;
        is_hold_2_n = 4'd0;

        if (!id_valid) begin
            stall_1_n = 4'd1;
            stall_2_n = 4'd1;
        end else begin
            case (state)
                RUN: begin
                    if (lu_1 || lu_2) begin
                        stall_1_n = 4'd1;
                        stall_2_n = 4'd1;
                        hold_c    = 1'b1;
                    end else if (split_dep) begin
                        forw_1a_n   = fwd_sel(id_rs1_1, id_use1_1, 1'b0);
                        forw_1b_n   = fwd_sel(id_rs2_1, id_use2_1, 1'b0);
                        is_hold_2_n = 4'd1;
                        hold_c      = 1'b1;
                        state_next  = SPLIT;
                    end else begin
                        forw_1a_n = fwd_sel(id_rs1_1, id_use1_1, 1'b0);
                        forw_1b_n = fwd_sel(id_rs2_1, id_use2_1, 1'b0);
                        forw_2a_n = fwd_sel(id_rs1_2, id_use1_2, 1'b1);
                        forw_2b_n = fwd_sel(id_rs2_2, id_use2_2, 1'b1);
                    end
                end
                SPLIT: begin
                    // Lane1 already issued; only lane2 of the held bundle remains.
                    is_hold_1_n = 4'd1;
                    if (lu_2) begin
                        stall_2_n = 4'd1;
                        hold_c    = 1'b1;
                    end else begin
                        forw_2a_n  = fwd_sel(id_rs1_2, id_use1_2, 1'b0);
                        forw_2b_n  = fwd_sel(id_rs2_2, id_use2_2, 1'b0);
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign pc_hold   = hold_c;
    assign ifid_hold = hold_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            forw_1A   <= '0;
            forw_1B   <= '0;
            forw_2A   <= '0;
            forw_2B   <= '0;
            stall_1   <= '0;
            stall_2   <= '0;
            is_hold_1 <= '0;
            is_hold_2 <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            forw_1A   <= forw_1a_n;
            forw_1B   <= forw_1b_n;
            forw_2A   <= forw_2a_n;
            forw_2B   <= forw_2b_n;
            stall_1   <= stall_1_n;
            stall_2   <= stall_2_n;
            is_hold_1 <= is_hold_1_n;
            is_hold_2 <= is_hold_2_n;
            if (hold_c && stall_cnt != '1)
                stall_cnt <= stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding priority, load-use bubble,
// intra-bundle split, x0/use-flag masking, counter saturation, reset mid-split.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1_1, id_rs2_1, id_rd_1, id_rs1_2, id_rs2_2;
    logic       id_use1_1, id_use2_1, id_we_1, id_load_1, id_use1_2, id_use2_2;
    logic [4:0] ex_rd_1, ex_rd_2, mem_rd_1, mem_rd_2;
    logic       ex_we_1, ex_we_2, ex_load_1, ex_load_2, mem_we_1, mem_we_2;
    logic [3:0] forw_1A, forw_1B, forw_2A, forw_2B;
    logic [3:0] stall_1, stall_2, is_hold_1, is_hold_2;
    logic       pc_hold, ifid_hold;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_1(id_rs1_1), .id_rs2_1(id_rs2_1), .id_use1_1(id_use1_1), .id_use2_1(id_use2_1),
        .id_rd_1(id_rd_1), .id_we_1(id_we_1), .id_load_1(id_load_1),
        .id_rs1_2(id_rs1_2), .id_rs2_2(id_rs2_2), .id_use1_2(id_use1_2), .id_use2_2(id_use2_2),
        .ex_rd_1(ex_rd_1), .ex_rd_2(ex_rd_2), .ex_we_1(ex_we_1), .ex_we_2(ex_we_2),
        .ex_load_1(ex_load_1), .ex_load_2(ex_load_2),
        .mem_rd_1(mem_rd_1), .mem_rd_2(mem_rd_2), .mem_we_1(mem_we_1), .mem_we_2(mem_we_2),
        .forw_1A(forw_1A), .forw_1B(forw_1B), .forw_2A(forw_2A), .forw_2B(forw_2B),
        .stall_1(stall_1), .stall_2(stall_2), .is_hold_1(is_hold_1), .is_hold_2(is_hold_2),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 1'b1;
        id_rs1_1 = '0; id_rs2_1 = '0; id_rd_1 = '0; id_rs1_2 = '0; id_rs2_2 = '0;
        id_use1_1 = 0; id_use2_1 = 0; id_we_1 = 0; id_load_1 = 0; id_use1_2 = 0; id_use2_2 = 0;
        ex_rd_1 = '0; ex_rd_2 = '0; mem_rd_1 = '0; mem_rd_2 = '0;
        ex_we_1 = 0; ex_we_2 = 0; ex_load_1 = 0; ex_load_2 = 0; mem_we_1 = 0; mem_we_2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_f1A"}, forw_1A, 0);
        chk({tag, "_f1B"}, forw_1B, 0);
        chk({tag, "_f2A"}, forw_2A, 0);
        chk({tag, "_f2B"}, forw_2B, 0);
        chk({tag, "_st1"}, stall_1, 0);
        chk({tag, "_st2"}, stall_2, 0);
        chk({tag, "_ih1"}, is_hold_1, 0);
        chk({tag, "_ih2"}, is_hold_2, 0);
        chk({tag, "_cnt"}, stall_cnt, 0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Test 1: EX lane B beats lane A; MEM lane B beats lane A
        clear_inputs();
        ex_rd_1 = 5; ex_we_1 = 1; ex_rd_2 = 5; ex_we_2 = 1;
        mem_rd_1 = 6; mem_we_1 = 1; mem_rd_2 = 6; mem_we_2 = 1;
        id_rs1_1 = 5; id_use1_1 = 1; id_rs2_1 = 6; id_use2_1 = 1;
        id_rs1_2 = 5; id_use1_2 = 1;
        #1 chk("t1_pc_hold", pc_hold, 0);
        tick();
        chk("t1_f1A_exB", forw_1A, 2);
        chk("t1_f1B_memB", forw_1B, 4);
        chk("t1_f2A_exB", forw_2A, 2);
        chk("t1_st1", stall_1, 0);
        chk("t1_st2", stall_2, 0);
        ex_we_2 = 0; mem_we_2 = 0;
        tick();
        chk("t1_f1A_exA", forw_1A, 1);
        chk("t1_f1B_memA", forw_1B, 3);
        chk("t1_f2A_exA", forw_2A, 1);

        // Test 2: same-cycle ALU1 result beats EX lane B
        clear_inputs();
        id_rd_1 = 7; id_we_1 = 1; id_rs2_2 = 7; id_use2_2 = 1;
        ex_rd_2 = 7; ex_we_2 = 1;
        #1 chk("t2_pc_hold", pc_hold, 0);
        tick();
        chk("t2_f2B", forw_2B, 8);
        chk("t2_st2", stall_2, 0);

        // Test 3: load-use -> one bubble, then forward from MEM/WB lane A
        clear_inputs();
        ex_load_1 = 1; ex_rd_1 = 3; ex_we_1 = 1; id_rs1_1 = 3; id_use1_1 = 1;
        #1 chk("t3_pc_hold", pc_hold, 1);
        chk("t3_ifid_hold", ifid_hold, 1);
        tick();
        exp_cnt = exp_cnt + 1;
        chk("t3_st1", stall_1, 1);
        chk("t3_st2", stall_2, 1);
        chk("t3_f1A_bubble", forw_1A, 0);
        chk("t3_cnt", stall_cnt, exp_cnt);
        ex_load_1 = 0; ex_we_1 = 0; ex_rd_1 = 0; mem_rd_1 = 3; mem_we_1 = 1;
        #1 chk("t3_pc_release", pc_hold, 0);
        tick();
        chk("t3_f1A_mem", forw_1A, 3);
        chk("t3_st1_issue", stall_1, 0);

        // Test 4: intra-bundle load dependency -> split, lane2 bubble, then issue
        clear_inputs();
        id_load_1 = 1; id_we_1 = 1; id_rd_1 = 9; id_rs1_2 = 9; id_use1_2 = 1;
        id_rs1_1 = 4; id_use1_1 = 1; mem_rd_2 = 4; mem_we_2 = 1;
        #1 chk("t4_pc_hold_split", pc_hold, 1);
        tick();
        exp_cnt = exp_cnt + 1;
        chk("t4_ih2", is_hold_2, 1);
        chk("t4_st2", stall_2, 0);
        chk("t4_f2A", forw_2A, 0);
        chk("t4_f1A", forw_1A, 4);
        chk("t4_ih1", is_hold_1, 0);
        mem_rd_2 = 0; mem_we_2 = 0;
        ex_rd_1 = 9; ex_we_1 = 1; ex_load_1 = 1;
        #1 chk("t4_pc_hold_lu", pc_hold, 1);
        tick();
        exp_cnt = exp_cnt + 1;
        chk("t4_split_st2", stall_2, 1);
        chk("t4_split_ih1", is_hold_1, 1);
        chk("t4_split_f1A", forw_1A, 0);
        ex_rd_1 = 0; ex_we_1 = 0; ex_load_1 = 0; mem_rd_1 = 9; mem_we_1 = 1;
        #1 chk("t4_pc_release", pc_hold, 0);
        tick();
        chk("t4_f2A_mem", forw_2A, 3);
        chk("t4_rel_ih1", is_hold_1, 1);
        chk("t4_rel_st2", stall_2, 0);
        chk("t4_rel_ih2", is_hold_2, 0);
        chk("t4_cnt", stall_cnt, exp_cnt);
        clear_inputs();
        id_rd_1 = 9; id_we_1 = 1; id_rs1_2 = 9; id_use1_2 = 1;
        tick();
        chk("t4_back_run", forw_2A, 8);
        chk("t4_back_ih1", is_hold_1, 0);

        // id_valid=0: bubbles, no hold even with a load-use pattern
        clear_inputs();
        id_valid = 0; ex_load_1 = 1; ex_rd_1 = 3; ex_we_1 = 1; id_rs1_1 = 3; id_use1_1 = 1;
        #1 chk("inv_pc_hold", pc_hold, 0);
        tick();
        chk("inv_st1", stall_1, 1);
        chk("inv_st2", stall_2, 1);

        // Test 5: x0 and unused sources never forward
        clear_inputs();
        id_rs1_1 = 0; id_use1_1 = 1; ex_rd_1 = 0; ex_we_1 = 1;
        id_rs2_1 = 5; id_use2_1 = 0; ex_rd_2 = 5; ex_we_2 = 1;
        tick();
        chk("t5_x0", forw_1A, 0);
        chk("t5_nouse", forw_1B, 0);

        // Counter saturation via sustained load-use
        clear_inputs();
        ex_load_1 = 1; ex_rd_1 = 3; ex_we_1 = 1; id_rs1_1 = 3; id_use1_1 = 1;
        repeat (65535 - exp_cnt) @(posedge clk);
        #1 chk("t5_cnt_sat", stall_cnt, 16'hffff);
        tick();
        chk("t5_cnt_hold", stall_cnt, 16'hffff);

        // Test 6: reset while in SPLIT
        clear_inputs();
        id_load_1 = 1; id_we_1 = 1; id_rd_1 = 9; id_rs1_2 = 9; id_use1_2 = 1;
        tick();
        chk("t6_in_split", is_hold_2, 1);
        rst = 1'b1;
        tick();
        chk_all_zero("t6_rst");
        rst = 1'b0;
        id_load_1 = 0;
        tick();
        chk("t6_run_f2A", forw_2A, 8);
        chk("t6_run_ih1", is_hold_1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
